ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Converts the PS/2 Set-2 scan-code byte stream from the PS/2 receiver into the synth control signals consumed by the IO controller.
- Outputs: held note/gate, one-cycle octave/amplitude/ADSR adjust pulses, and the ADSR parameter selector.
- Sits directly upstream of the IO controller's parameter registers and ALUcontroller note inputs.
- Handles make, break (F0) and extended (E0) prefixes, typematic-repeat suppression and prefix timeout.

Parameters:
- TIMEOUT_CYCLES, 1000000: clk cycles allowed between a prefix byte and its following byte before the FSM abandons the sequence (20 ms at 50 MHz).
- TO_W, 20: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-low
- scancode  in  8  received PS/2 byte
- scancode_valid  in  1  one-cycle strobe; scancode valid this cycle
- note  out  4  current note 0..11 (C..B)
- note_in  out  1  gate; high while the sounding note key is held
- octave_plus_plus  out  1  one-cycle pulse
- octave_minus_minus  out  1  one-cycle pulse
- amp_plus_plus  out  1  one-cycle pulse
- amp_minus_minus  out  1  one-cycle pulse
- ADSR_selector  out  3  0 amp, 1 attack, 2 decay, 3 sustain, 4 release
- ADSR_plus_plus  out  1  one-cycle pulse
- ADSR_minus_minus  out  1  one-cycle pulse

Behaviour:
- Reset: clock clk; reset is synchronous, active-low. While reset=0:
  - note=0, note_in=0, all pulses 0, ADSR_selector=0.
  - held flags cleared, FSM=IDLE, timeout counter=0.
  - scancode_valid is ignored.
- FSM states, advanced only on scancode_valid:
  - IDLE: F0->BRK, E0->EXT, other byte=make code (process), stay IDLE.
  - BRK: E0->EXT_BRK; other byte=break code (process), ->IDLE.
  - EXT: F0->EXT_BRK; E0 stays EXT; other=extended make (process), ->IDLE.
  - EXT_BRK: any byte=extended break (process), ->IDLE.
- Timeout: in BRK/EXT/EXT_BRK, the counter increments each cycle without scancode_valid. On reaching TIMEOUT_CYCLES-1, the FSM returns to IDLE with no event. The counter clears on every scancode_valid and in IDLE.
- Note keys, in order C..B (0..11): 1C,1D,1B,24,23,2B,2C,34,35,33,3C,3B.
  - Make: note<=index, note_in<=1 (last-note priority).
  - Repeated make of the same key: no visible change.
  - Break of the key equal to current note: note_in<=0, note unchanged.
  - Break of any other note key: ignored.
- Pulse keys (non-extended): 1A octave_minus_minus, 22 octave_plus_plus, 4E amp_minus_minus, 55 amp_plus_plus.
- Pulse keys (extended): E0 75 ADSR_plus_plus, E0 72 ADSR_minus_minus.
- Pulse rules:
  - Each pulse key has a held flag.
  - Make with flag clear: set flag and assert the pulse for exactly one cycle.
  - Make with flag set (typematic repeat): no pulse.
  - Break: clears the flag, no pulse.
  - At most one pulse per scancode byte.
- Selector keys 16,1E,26,25,2E (digits 1..5): make sets ADSR_selector to 0..4 and holds it until the next selector make or reset.
- Unmapped codes, or extended codes not listed: no output change, FSM returns to IDLE per table.
- Latency: every output change is registered and appears on the cycle after the scancode_valid carrying the final byte. Pulses deassert on the following cycle.
- Reset mid-sequence (e.g. after F0) discards the prefix. The next byte is treated as a make.

Test Plan:
- Reset, then bytes 1C -> next cycle note=0, note_in=1. Then F0,1C -> note_in=0, note=0.
- 1C, 3B, then F0 1C -> note=11, note_in stays 1. Then F0 3B -> note_in=0.
- 22 sent 3 times (typematic), then F0 22, then 22 -> octave_plus_plus high exactly 1 cycle after the first 22, and again after the final 22. Two pulses total.
- 26, then E0 75, then E0 F0 75, then E0 72 -> ADSR_selector=2; one ADSR_plus_plus pulse, one ADSR_minus_minus pulse; no pulse on the break.
- F0 then idle TIMEOUT_CYCLES (TIMEOUT_CYCLES=16 in sim), then 1C -> treated as make: note=0, note_in=1.
- Reset asserted one cycle after E0, then 72 -> no ADSR_minus_minus pulse; 72 is unmapped non-extended, so all outputs stay at reset values.

Source files
------------

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// ps2_key_decoder: PS/2 Set-2 scan-code stream to synth note/gate, one-cycle
// adjust pulses and ADSR parameter selector.   Revision 1.0
// ============================================================================
module ps2_key_decoder #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TO_W           = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] scancode,
   input  logic       scancode_valid,
   output logic [3:0] note,
   output logic       note_in,
   output logic       octave_plus_plus,
   output logic       octave_minus_minus,
   output logic       amp_plus_plus,
   output logic       amp_minus_minus,
   output logic [2:0] ADSR_selector,
   output logic       ADSR_plus_plus,
   output logic       ADSR_minus_minus
);
   localparam logic [7:0]      BRK_PREFIX   = 8'hF0;
   localparam logic [7:0]      EXT_PREFIX   = 8'hE0;
   localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   state_t          state;
   logic [TO_W-1:0] to_cnt;
   logic [5:0]      held;
   logic [5:0]      pulse;

   logic       ev, ev_ext, ev_brk;
   logic       note_hit;
   logic [3:0] note_idx;
   logic [5:0] pulse_mask;
   logic       sel_hit;
   logic [2:0] sel_val;

   // A byte completes an event unless it is a prefix that extends the sequence.
   always_comb begin
      ev     = 1'b0;
      ev_ext = 1'b0;
      ev_brk = 1'b0;
      if (scancode_valid) begin
         case (state)
            IDLE:    ev = (scancode != BRK_PREFIX) && (scancode != EXT_PREFIX);
            BRK: begin
               ev     = (scancode != EXT_PREFIX);
               ev_brk = 1'b1;
            end
            EXT: begin
               ev     = (scancode != BRK_PREFIX) && (scancode != EXT_PREFIX);
               ev_ext = 1'b1;
            end
            default: begin
               ev     = 1'b1;
               ev_ext = 1'b1;
               ev_brk = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      note_hit = 1'b1;
      note_idx = 4'd0;
      case (scancode)
         8'h1C:   note_idx = 4'd0;
         8'h1D:   note_idx = 4'd1;
         8'h1B:   note_idx = 4'd2;
         8'h24:   note_idx = 4'd3;
         8'h23:   note_idx = 4'd4;
         8'h2B:   note_idx = 4'd5;
         8'h2C:   note_idx = 4'd6;
         8'h34:   note_idx = 4'd7;
         8'h35:   note_idx = 4'd8;
         8'h33:   note_idx = 4'd9;
         8'h3C:   note_idx = 4'd10;
         8'h3B:   note_idx = 4'd11;
         default: note_hit = 1'b0;
      endcase
   end

   // Mask bits: 0 oct-, 1 oct+, 2 amp-, 3 amp+, 4 ADSR+, 5 ADSR-.
   always_comb begin
      pulse_mask = 6'b0;
      case ({ev_ext, scancode})
         9'h01A:  pulse_mask = 6'b000001;
         9'h022:  pulse_mask = 6'b000010;
         9'h04E:  pulse_mask = 6'b000100;
         9'h055:  pulse_mask = 6'b001000;
         9'h175:  pulse_mask = 6'b010000;
         9'h172:  pulse_mask = 6'b100000;
         default: pulse_mask = 6'b0;
      endcase
   end

   always_comb begin
      sel_hit = 1'b1;
      sel_val = 3'd0;
      case (scancode)
         8'h16:   sel_val = 3'd0;
         8'h1E:   sel_val = 3'd1;
         8'h26:   sel_val = 3'd2;
         8'h25:   sel_val = 3'd3;
         8'h2E:   sel_val = 3'd4;
         default: sel_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         to_cnt        <= '0;
         held          <= '0;
         pulse         <= '0;
         note          <= 4'd0;
         note_in       <= 1'b0;
         ADSR_selector <= 3'd0;
      end else begin
         pulse <= '0;
         if (scancode_valid) begin
            to_cnt <= '0;
            case (state)
               IDLE: begin
                  if (scancode == BRK_PREFIX)      state <= BRK;
                  else if (scancode == EXT_PREFIX) state <= EXT;
               end
               BRK:  state <= (scancode == EXT_PREFIX) ? EXT_BRK : IDLE;
               EXT: begin
                  if (scancode == BRK_PREFIX)      state <= EXT_BRK;
                  else if (scancode != EXT_PREFIX) state <= IDLE;
               end
               default: state <= IDLE;
            endcase

            if (ev) begin
               if (note_hit && !ev_ext) begin
                  if (!ev_brk) begin
                     note    <= note_idx;
                     note_in <= 1'b1;
                  end else if (note_idx == note) begin
                     note_in <= 1'b0;
                  end
               end
               // Held flags suppress typematic repeats until the key is released.
               if (ev_brk) begin
                  held <= held & ~pulse_mask;
               end else begin
                  held  <= held | pulse_mask;
                  pulse <= pulse_mask & ~held;
               end
               if (sel_hit && !ev_ext && !ev_brk)
                  ADSR_selector <= sel_val;
            end
         end else if (state != IDLE) begin
            if (to_cnt == TIMEOUT_LAST) begin
               state  <= IDLE;
               to_cnt <= '0;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

   assign octave_minus_minus = pulse[0];
   assign octave_plus_plus   = pulse[1];
   assign amp_minus_minus    = pulse[2];
   assign amp_plus_plus      = pulse[3];
   assign ADSR_plus_plus     = pulse[4];
   assign ADSR_minus_minus   = pulse[5];

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// tb_ps2_key_decoder: directed scan-code sequences with a queue of expected
// output snapshots.   Revision 1.0
// ============================================================================
module tb_ps2_key_decoder;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] scancode = 8'h00;
   logic       scancode_valid = 1'b0;
   logic [3:0] note;
   logic       note_in;
   logic       octave_plus_plus, octave_minus_minus;
   logic       amp_plus_plus, amp_minus_minus;
   logic [2:0] ADSR_selector;
   logic       ADSR_plus_plus, ADSR_minus_minus;

   int checks = 0;
   int errors = 0;
   logic [13:0] sb[$];

   ps2_key_decoder #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
      .clk                (clk),
      .reset              (reset),
      .scancode           (scancode),
      .scancode_valid     (scancode_valid),
      .note               (note),
      .note_in            (note_in),
      .octave_plus_plus   (octave_plus_plus),
      .octave_minus_minus (octave_minus_minus),
      .amp_plus_plus      (amp_plus_plus),
      .amp_minus_minus    (amp_minus_minus),
      .ADSR_selector      (ADSR_selector),
      .ADSR_plus_plus     (ADSR_plus_plus),
      .ADSR_minus_minus   (ADSR_minus_minus)
   );

   always #5 clk = ~clk;

   // Pulse field order: oct+, oct-, amp+, amp-, ADSR+, ADSR-.
   localparam logic [5:0] P_NONE = 6'b000000;
   localparam logic [5:0] P_OCTP = 6'b100000;
   localparam logic [5:0] P_ADP  = 6'b000010;
   localparam logic [5:0] P_ADM  = 6'b000001;

   function automatic logic [13:0] ev(input logic [3:0] n, input logic g,
                                      input logic [5:0] p, input logic [2:0] s);
      return {n, g, p, s};
   endfunction

   function automatic logic [13:0] observed();
      return {note, note_in, octave_plus_plus, octave_minus_minus, amp_plus_plus,
              amp_minus_minus, ADSR_plus_plus, ADSR_minus_minus, ADSR_selector};
   endfunction

   task automatic compare(input string tag, input logic [13:0] exp);
      logic [13:0] obs;
      obs = observed();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one byte; check the registered result, then that pulses dropped.
   task automatic send(input string tag, input logic [7:0] b, input logic [13:0] exp);
      logic [13:0] e;
      sb.push_back(exp);
      @(negedge clk);
      scancode       = b;
      scancode_valid = 1'b1;
      @(posedge clk);
      #1;
      scancode_valid = 1'b0;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         compare(tag, e);
         @(posedge clk);
         #1;
         compare({tag, "_after"}, {e[13:9], 6'b0, e[2:0]});
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      compare(tag, ev(4'd0, 1'b0, P_NONE, 3'd0));
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      // Bytes presented while reset is low must be ignored.
      scancode       = 8'h22;
      scancode_valid = 1'b1;
      do_reset("reset_state");
      scancode_valid = 1'b0;

      send("make_c",       8'h1C, ev(4'd0, 1'b1, P_NONE, 3'd0));
      send("brk_prefix",   8'hF0, ev(4'd0, 1'b1, P_NONE, 3'd0));
      send("brk_c",        8'h1C, ev(4'd0, 1'b0, P_NONE, 3'd0));

      send("make_c2",      8'h1C, ev(4'd0,  1'b1, P_NONE, 3'd0));
      send("make_b",       8'h3B, ev(4'd11, 1'b1, P_NONE, 3'd0));
      send("f0_a",         8'hF0, ev(4'd11, 1'b1, P_NONE, 3'd0));
      send("brk_other",    8'h1C, ev(4'd11, 1'b1, P_NONE, 3'd0));
      send("f0_b",         8'hF0, ev(4'd11, 1'b1, P_NONE, 3'd0));
      send("brk_b",        8'h3B, ev(4'd11, 1'b0, P_NONE, 3'd0));

      send("oct_first",    8'h22, ev(4'd11, 1'b0, P_OCTP, 3'd0));
      send("oct_rep1",     8'h22, ev(4'd11, 1'b0, P_NONE, 3'd0));
      send("oct_rep2",     8'h22, ev(4'd11, 1'b0, P_NONE, 3'd0));
      send("oct_f0",       8'hF0, ev(4'd11, 1'b0, P_NONE, 3'd0));
      send("oct_brk",      8'h22, ev(4'd11, 1'b0, P_NONE, 3'd0));
      send("oct_again",    8'h22, ev(4'd11, 1'b0, P_OCTP, 3'd0));

      send("sel_decay",    8'h26, ev(4'd11, 1'b0, P_NONE, 3'd2));
      send("e0_a",         8'hE0, ev(4'd11, 1'b0, P_NONE, 3'd2));
      send("adsr_plus",    8'h75, ev(4'd11, 1'b0, P_ADP,  3'd2));
      send("e0_b",         8'hE0, ev(4'd11, 1'b0, P_NONE, 3'd2));
      send("e0_f0",        8'hF0, ev(4'd11, 1'b0, P_NONE, 3'd2));
      send("adsr_plus_brk",8'h75, ev(4'd11, 1'b0, P_NONE, 3'd2));
      send("e0_c",         8'hE0, ev(4'd11, 1'b0, P_NONE, 3'd2));
      send("adsr_minus",   8'h72, ev(4'd11, 1'b0, P_ADM,  3'd2));

      // Abandoned break prefix: the following byte is a make again.
      send("to_f0",        8'hF0, ev(4'd11, 1'b0, P_NONE, 3'd2));
      repeat (20) @(posedge clk);
      send("to_make",      8'h1C, ev(4'd0,  1'b1, P_NONE, 3'd2));
      send("sel_release",  8'h2E, ev(4'd0,  1'b1, P_NONE, 3'd4));

      send("mid_e0",       8'hE0, ev(4'd0,  1'b1, P_NONE, 3'd4));
      do_reset("mid_reset");
      send("post_rst_72",  8'h72, ev(4'd0,  1'b0, P_NONE, 3'd0));
      // Held flags cleared by reset: a fresh extended make pulses again.
      send("post_rst_e0",  8'hE0, ev(4'd0,  1'b0, P_NONE, 3'd0));
      send("post_rst_adm", 8'h72, ev(4'd0,  1'b0, P_ADM,  3'd0));

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
